// File: rtl/data_memory_arbiter.sv
// Purpose : shares the single-port data memory between the CORE load/store port and the DMA loader.
// Latency : grant and mem_* are same-cycle combinational; read data and oob_err arrive one cycle later.
// Backpr. : a requester holds req/we/addr/wdata until its gnt; DMA bursts lock out CORE for up to MAX_BURST beats.
//
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   core_req/we/addr/wdata -> gnt   CORE request and same-cycle grant; core_rdata/core_rvalid read return
//   dma_req/we/addr/wdata/last      DMA request, dma_last marks the final beat of a burst
//   dma_gnt, dma_rdata, dma_rvalid  DMA grant and read return
//   mem_we/mem_addr/mem_wd, mem_rd  data memory port (mem_rd is a combinational read of mem_addr)
//   oob_err                         one-cycle pulse after an out-of-range transfer
module data_memory_arbiter #(
    parameter int DEPTH     = 256,
    parameter int MAX_BURST = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic [31:0] core_rdata,
    output logic        core_rvalid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_last,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        oob_err
);

    localparam int          CW      = $clog2(MAX_BURST + 1);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    localparam logic [0:0] S_RR       = 1'b0;
    localparam logic [0:0] S_DMA_LOCK = 1'b1;

    logic [0:0]    r_state;
    logic          r_last_dma;     // 1: DMA had the most recent transfer, so CORE wins the next tie
    logic [CW-1:0] r_beat_cnt;
    logic [31:0]   r_core_rdata;
    logic          r_core_rvalid;
    logic [31:0]   r_dma_rdata;
    logic          r_dma_rvalid;
    logic          r_oob_err;

    logic          w_core_gnt;
    logic          w_dma_gnt;
    logic          w_core_in;
    logic          w_dma_in;
    logic [CW-1:0] w_beat_inc;
    logic          w_cap;

    assign w_core_in  = (core_addr < DEPTH_W);
    assign w_dma_in   = (dma_addr < DEPTH_W);
    assign w_beat_inc = r_beat_cnt + CW'(1);
    assign w_cap      = (w_beat_inc >= CW'(MAX_BURST));

    // Grant is gated by RST_N so nothing reaches the memory while reset is held.
    always_comb begin
        w_core_gnt = 1'b0;
        w_dma_gnt  = 1'b0;
        if (RST_N) begin
            if (r_state == S_DMA_LOCK) begin
                w_dma_gnt = dma_req;
            end else if (core_req && dma_req) begin
                w_core_gnt = r_last_dma;
                w_dma_gnt  = !r_last_dma;
            end else begin
                w_core_gnt = core_req;
                w_dma_gnt  = dma_req;
            end
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = 32'd0;
        mem_wd   = 32'd0;
        if (w_dma_gnt) begin
            mem_we   = dma_we & w_dma_in;
            mem_addr = dma_addr;
            mem_wd   = dma_wdata;
        end else if (w_core_gnt) begin
            mem_we   = core_we & w_core_in;
            mem_addr = core_addr;
            mem_wd   = core_wdata;
        end
    end

    // Arbitration state: round-robin history and the DMA burst lock.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_RR;
            r_last_dma <= 1'b1;
            r_beat_cnt <= '0;
        end else if (r_state == S_RR) begin
            if (w_core_gnt) begin
                r_last_dma <= 1'b0;
            end else if (w_dma_gnt) begin
                r_last_dma <= 1'b1;
                if (!dma_last) begin
                    r_state    <= S_DMA_LOCK;
                    r_beat_cnt <= CW'(1);
                end
            end
        end else begin
            // Leaving the lock always hands the next tie to CORE.
            if (!dma_req || dma_last || w_cap) begin
                r_state    <= S_RR;
                r_beat_cnt <= '0;
                r_last_dma <= 1'b1;
            end else begin
                r_beat_cnt <= w_beat_inc;
            end
        end
    end

    // Read return: mem_rd belongs to whichever side was granted this cycle.
    // Out-of-range reads still complete, but with zero data.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_core_rdata  <= 32'd0;
            r_core_rvalid <= 1'b0;
            r_dma_rdata   <= 32'd0;
            r_dma_rvalid  <= 1'b0;
            r_oob_err     <= 1'b0;
        end else begin
            r_core_rvalid <= w_core_gnt & !core_we;
            r_dma_rvalid  <= w_dma_gnt & !dma_we;
            if (w_core_gnt && !core_we) begin
                r_core_rdata <= w_core_in ? mem_rd : 32'd0;
            end
            if (w_dma_gnt && !dma_we) begin
                r_dma_rdata <= w_dma_in ? mem_rd : 32'd0;
            end
            r_oob_err <= (w_core_gnt & !w_core_in) | (w_dma_gnt & !w_dma_in);
        end
    end

    assign core_gnt    = w_core_gnt;
    assign dma_gnt     = w_dma_gnt;
    assign core_rdata  = r_core_rdata;
    assign core_rvalid = r_core_rvalid;
    assign dma_rdata   = r_dma_rdata;
    assign dma_rvalid  = r_dma_rvalid;
    assign oob_err     = r_oob_err;

endmodule
